fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Parametrised successor to the single-register fetch stage of the 5-stage MIPS pipeline.
- A PC generator feeds a circular instruction prefetch queue of depth QDEPTH, which decouples fetch from decode stalls.
- The D-stage pipeline register (IRD/PC4D/ExcCodeD/ValidD) sits at the queue output.
- Handles branch/jump redirect with delay slot, exception entry, eret, and AdEL detection on fetch.

Parameters:
- QDEPTH, 4: queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_3000: PC after reset.
- EXC_HANDLER, 32'h0000_4180: PC loaded on exception entry.
- IM_BASE, 32'h0000_3000: lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC: highest legal fetch address, inclusive.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ImAddr  out  32  instruction-memory word address; equals PC.
- ImData  in  32  IM read data, combinational from ImAddr.
- NPC  in  32  branch/jump/jr target resolved in D.
- Redirect  in  1  D-stage control transfer taken this cycle.
- StallD  in  1  hazard unit: hold the D register.
- exp_in  in  1  exception/interrupt taken from M.
- exp_out  in  1  eret committed.
- EPC  in  32  return address for eret.
- IRD  out  32  D instruction.
- PC4D  out  32  D instruction PC+4.
- ExcCodeD  out  [6:2]  fetch exception code carried to D.
- ValidD  out  1  D holds a real instruction, not a bubble.
- QCount  out  $clog2(QDEPTH)+1  queue occupancy.

Behaviour:
- Reset (sync, highest priority):
  - PC=RESET_PC; queue emptied; rd/wr pointers=0.
  - IRD=0, PC4D=0, ExcCodeD=0, ValidD=0, QCount=0.
- Fetch word formation, every cycle:
  - entry = {PC, instr, exc}.
  - If PC[1:0]!=0 or PC<IM_BASE or PC>IM_LIMIT: exc=5'd4 (AdEL), instr=32'h0.
  - Otherwise exc=0, instr=ImData.
- Head: queue head entry if QCount>0; otherwise the current fetch word (zero-latency bypass).
- Pop: occurs when !StallD. D loads the head (IRD=instr, PC4D=PC+4, ExcCodeD=exc, ValidD=1).
- StallD=1: D register and queue head hold.
- Push:
  - Occurs when QCount<QDEPTH, or when QCount==QDEPTH with a pop this cycle.
  - The bypass case (empty queue and pop) consumes the fetch without a push.
  - On push or bypass, PC<=PC+4. Full with no pop: PC holds, no push.
- QCount arithmetic: +1 on push only, -1 on pop from queue only, unchanged when both occur. Pointers wrap modulo QDEPTH.
- Control events, priority exp_in > exp_out > Redirect; all are evaluated in the same cycle:
  - exp_in: queue flushed; D loads bubble (all zero, ValidD=0) regardless of StallD; PC<=EXC_HANDLER.
  - exp_out: queue flushed; D bubble; PC<=EPC. No delay slot.
  - Redirect with !StallD:
    - D loads the head as the delay slot (bypass if empty).
    - All remaining queue entries are flushed; PC<=NPC.
    - A fetch word bypassed into D as the delay slot is not pushed.
  - Redirect with StallD: ignored. D re-presents Redirect next cycle.
- A misaligned or out-of-range NPC/EPC is loaded unchanged. The fault surfaces as AdEL on the subsequent fetch.
- No combinational path from Redirect/NPC to IRD. ImAddr depends only on registered PC.

Test Plan:
- Reset, then free-run with ImData=PC: ImAddr 0x3000, 0x3004, 0x3008…; D gets IRD=0x3000 with PC4D=0x3004 one cycle after reset release; ValidD=1; QCount stays 0 (bypass).
- StallD=1 for 6 cycles from PC=0x3000: queue fills to QCount=4, PC freezes at 0x3010, IRD holds. Release: D pops 0x3000…0x300C in order with no gaps while PC resumes.
- Redirect=1, NPC=0x5000 while queue holds 0x3004..0x3010: D gets the 0x3004 delay slot; QCount=0; next ImAddr=0x5000.
- NPC=0x3001 redirect: D receives ExcCodeD=4, IRD=0. NPC=0x1000 redirect: ExcCodeD=4, ValidD=1.
- exp_in=1 and Redirect=1 in the same cycle with StallD=1: D bubble (ValidD=0); PC=0x4180; queue empty. Then exp_out=1 with EPC=0x3020: ImAddr=0x3020 next cycle; D bubble.
- Reset asserted with queue full and StallD=1: next cycle QCount=0, ValidD=0, ImAddr=0x3000.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a circular prefetch queue between the PC generator and the
// D-stage register; the queue lets fetch keep running while decode is stalled.
module fetch_queue_stage #(
  parameter int          QDEPTH      = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] IM_BASE     = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT    = 32'h0000_6FFC
) (
  input  logic                      Clk,
  input  logic                      Reset,
  output logic [31:0]               ImAddr,
  input  logic [31:0]               ImData,
  input  logic [31:0]               NPC,
  input  logic                      Redirect,
  input  logic                      StallD,
  input  logic                      exp_in,
  input  logic                      exp_out,
  input  logic [31:0]               EPC,
  output logic [31:0]               IRD,
  output logic [31:0]               PC4D,
  output logic [6:2]                ExcCodeD,
  output logic                      ValidD,
  output logic [$clog2(QDEPTH):0]   QCount
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } entry_t;

  entry_t          q [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     pc;

  entry_t fetch, head;
  logic   empty, bad, pop, pop_q, bypass, push, flush_ev, redir, q_we;

  assign ImAddr = pc;
  assign QCount = count;

  // Out-of-range or misaligned PC becomes an AdEL word with a null instruction.
  assign bad = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);

  always_comb begin
    fetch.pc    = pc;
    fetch.instr = bad ? 32'h0 : ImData;
    fetch.exc   = bad ? 5'd4 : 5'd0;
  end

  assign empty    = (count == '0);
  assign head     = empty ? fetch : q[rd_ptr];
  assign flush_ev = exp_in || exp_out;
  assign redir    = Redirect && !StallD;
  assign pop      = !StallD;
  assign pop_q    = pop && !empty;
  assign bypass   = pop && empty;
  assign push     = !bypass && ((count < CW'(QDEPTH)) || pop);
  assign q_we     = push && !flush_ev && !redir && !Reset;

  always_ff @(posedge Clk) begin
    if (q_we) q[wr_ptr] <= fetch;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      IRD      <= 32'h0;
      PC4D     <= 32'h0;
      ExcCodeD <= 5'd0;
      ValidD   <= 1'b0;
    end else if (flush_ev) begin
      // Exceptions and eret drop everything in flight, stalled or not.
      pc       <= exp_in ? EXC_HANDLER : EPC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      IRD      <= 32'h0;
      PC4D     <= 32'h0;
      ExcCodeD <= 5'd0;
      ValidD   <= 1'b0;
    end else if (redir) begin
      // Head becomes the delay slot; everything behind it is wrong-path.
      pc       <= NPC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      IRD      <= head.instr;
      PC4D     <= head.pc + 32'd4;
      ExcCodeD <= head.exc;
      ValidD   <= 1'b1;
    end else begin
      if (pop) begin
        IRD      <= head.instr;
        PC4D     <= head.pc + 32'd4;
        ExcCodeD <= head.exc;
        ValidD   <= 1'b1;
      end
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (pop_q) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop_q);
      if (push || bypass) pc <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench: stimulus pushes the expected D-register load, a monitor
// pops and compares on every cycle in which D is allowed to load.
module tb_fetch_queue_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ImAddr, ImData, NPC, EPC, IRD, PC4D;
  logic        Redirect, StallD, exp_in, exp_out, ValidD;
  logic [6:2]  ExcCodeD;
  logic [2:0]  QCount;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic [4:0]  exc;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_queue_stage dut (
    .Clk(Clk), .Reset(Reset), .ImAddr(ImAddr), .ImData(ImData), .NPC(NPC),
    .Redirect(Redirect), .StallD(StallD), .exp_in(exp_in), .exp_out(exp_out),
    .EPC(EPC), .IRD(IRD), .PC4D(PC4D), .ExcCodeD(ExcCodeD), .ValidD(ValidD),
    .QCount(QCount)
  );

  always #5 Clk = ~Clk;

  // Instruction memory returns its own address as the instruction word.
  always_comb ImData = ImAddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_d(input logic [31:0] ir, input logic [31:0] pc4, input logic [4:0] exc, input logic v);
    exp_t e;
    e.ir = ir; e.pc4 = pc4; e.exc = exc; e.v = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] npc,
                       input logic ei, input logic eo, input logic [31:0] epc);
    StallD = st; Redirect = rd; NPC = npc; exp_in = ei; exp_out = eo; EPC = epc;
    @(negedge Clk);
  endtask

  // Monitor: D loads on any non-reset edge without stall, or on a flush event.
  initial begin
    forever begin
      logic ld;
      exp_t e;
      @(posedge Clk);
      ld = !Reset && (!StallD || exp_in || exp_out);
      #1;
      if (ld) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_load: IRD %h PC4D %h with no expectation at %0t", IRD, PC4D, $time);
        end else begin
          e = sb.pop_front();
          chk("IRD", IRD, e.ir);
          chk("PC4D", PC4D, e.pc4);
          chk("ExcCodeD", 32'(ExcCodeD), 32'(e.exc));
          chk("ValidD", 32'(ValidD), 32'(e.v));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; StallD = 1'b0; Redirect = 1'b0; NPC = '0;
    exp_in = 1'b0; exp_out = 1'b0; EPC = '0;
    @(negedge Clk); @(negedge Clk);
    chk("rst_imaddr", ImAddr, 32'h3000);
    chk("rst_qcount", 32'(QCount), 0);
    chk("rst_validd", 32'(ValidD), 0);
    chk("rst_ird", IRD, 0);
    Reset = 1'b0;

    // Free run: zero-latency bypass, queue stays empty.
    for (int i = 0; i < 3; i++) begin
      chk("run_imaddr", ImAddr, 32'h3000 + 32'(4 * i));
      chk("run_qcount", 32'(QCount), 0);
      exp_d(32'h3000 + 32'(4 * i), 32'h3004 + 32'(4 * i), 5'd0, 1'b1);
      drive(0, 0, 0, 0, 0, 0);
    end

    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    chk("rst2_validd", 32'(ValidD), 0);

    // Stall fills the queue, then drains in order while fetch continues.
    repeat (6) drive(1, 0, 0, 0, 0, 0);
    chk("full_qcount", 32'(QCount), 4);
    chk("full_imaddr", ImAddr, 32'h3010);
    chk("full_validd", 32'(ValidD), 0);
    for (int i = 0; i < 4; i++) begin
      exp_d(32'h3000 + 32'(4 * i), 32'h3004 + 32'(4 * i), 5'd0, 1'b1);
      drive(0, 0, 0, 0, 0, 0);
    end
    chk("drain_qcount", 32'(QCount), 4);
    chk("drain_imaddr", ImAddr, 32'h3020);

    // Redirect with a full queue: head is the delay slot, rest flushed.
    exp_d(32'h3010, 32'h3014, 5'd0, 1'b1);
    drive(0, 1, 32'h5000, 0, 0, 0);
    chk("redir_qcount", 32'(QCount), 0);
    chk("redir_imaddr", ImAddr, 32'h5000);
    exp_d(32'h5000, 32'h5004, 5'd0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);

    // Misaligned and out-of-range targets surface as AdEL.
    exp_d(32'h5004, 32'h5008, 5'd0, 1'b1);
    drive(0, 1, 32'h3001, 0, 0, 0);
    chk("mis_imaddr", ImAddr, 32'h3001);
    exp_d(32'h0, 32'h3005, 5'd4, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    exp_d(32'h0, 32'h3009, 5'd4, 1'b1);
    drive(0, 1, 32'h1000, 0, 0, 0);
    exp_d(32'h0, 32'h1004, 5'd4, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    exp_d(32'h0, 32'h1008, 5'd4, 1'b1);
    drive(0, 1, 32'h6FFC, 0, 0, 0);
    exp_d(32'h6FFC, 32'h7000, 5'd0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    exp_d(32'h0, 32'h7004, 5'd4, 1'b1);
    drive(0, 0, 0, 0, 0, 0);

    // Exception beats redirect and stall; then eret.
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    chk("pre_exc_qcount", 32'(QCount), 2);
    exp_d(32'h0, 32'h0, 5'd0, 1'b0);
    drive(1, 1, 32'h5000, 1, 0, 0);
    chk("exc_qcount", 32'(QCount), 0);
    chk("exc_imaddr", ImAddr, 32'h4180);
    chk("exc_validd", 32'(ValidD), 0);
    exp_d(32'h0, 32'h0, 5'd0, 1'b0);
    drive(0, 0, 0, 0, 1, 32'h3020);
    chk("eret_imaddr", ImAddr, 32'h3020);
    chk("eret_qcount", 32'(QCount), 0);
    exp_d(32'h3020, 32'h3024, 5'd0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);

    // Reset while full and stalled.
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    chk("pre_rst_qcount", 32'(QCount), 4);
    chk("pre_rst_imaddr", ImAddr, 32'h3034);
    Reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    chk("rst3_qcount", 32'(QCount), 0);
    chk("rst3_validd", 32'(ValidD), 0);
    chk("rst3_imaddr", ImAddr, 32'h3000);
    chk("rst3_ird", IRD, 0);
    Reset = 1'b0;
    exp_d(32'h3000, 32'h3004, 5'd0, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
